pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/forward sequencer for the 5-stage 8-bit pipeline (IF/ID/EX/MEM/WB).
//  - Drives enable and flush for the PC and each pipeline register (IFID, IDEX, EXMEM, MEMWB).
//  - Detects RAW and load-use hazards, applies branch flushes, freezes the pipeline on data-memory wait.
//  - Selects the EX operand bypass source.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 9 +
 rtl/hazard_match.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types for the hazard sequencer (package pipe_pkg)
//   state_t   : INIT (post-reset bubbles), RUN, MEM_WAIT (frozen on data memory)
//   FWD_*     : EX operand bypass select encodings
package pipe_pkg;
    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares two source addresses against one producer destination
//   rs1, rs2   in  AW  source register addresses
//   use1, use2 in  1   source is actually read
//   wa, we     in  AW,1 producer destination address / write enable
//   hit1, hit2 out 1   source x depends on this producer
module hazard_match #(
    parameter int AW = 8
) (
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic          use1,
    input  logic          use2,
    input  logic [AW-1:0] wa,
    input  logic          we,
    output logic          hit1,
    output logic          hit2
);
    assign hit1 = we && use1 && (rs1 == wa);
    assign hit2 = we && use2 && (rs2 == wa);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward sequencer for the 5-stage pipeline
//   Optional feature macro: HAZARD_FORWARD_EN (EX bypass; only load-use stalls)
//   clk, rst_n                       clock, async active-low reset
//   id_rs1/2, id_use1/2              ID sources and their use flags
//   ex_rs1/2                         EX sources (bypass selection)
//   ex_wa/ex_RegWrite/ex_MemRead     EX producer
//   mem_wa/mem_RegWrite              MEM producer
//   wb_wa/wb_RegWrite                WB producer
//   ex_branch_taken                  taken branch resolved in EX
//   mem_req, mem_ready               data-memory handshake in MEM
//   pc_en..memwb_en                  stage enables (0 = hold)
//   ifid_flush, idex_flush           load bubble on next edge
//   fwd_a, fwd_b                     bypass select (pipe_pkg FWD_*)
//   stall_cnt                        saturating count of pc_en=0 cycles in RUN/MEM_WAIT
module pipeline_hazard_ctrl #(
    parameter int AW         = 8,
    parameter int INIT_FLUSH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [AW-1:0]    ex_rs1,
    input  logic [AW-1:0]    ex_rs2,
    input  logic [AW-1:0]    ex_wa,
    input  logic             ex_RegWrite,
    input  logic             ex_MemRead,
    input  logic [AW-1:0]    mem_wa,
    input  logic             mem_RegWrite,
    input  logic [AW-1:0]    wb_wa,
    input  logic             wb_RegWrite,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);
    import pipe_pkg::*;

    localparam int IW = (INIT_FLUSH > 1) ? $clog2(INIT_FLUSH) : 1;
    localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_FLUSH - 1);

    state_t        state;
    logic [IW-1:0] init_cnt;
    logic          ex_hit1, ex_hit2;
    logic          stall, freeze, go, is_init;

    hazard_match #(.AW(AW)) u_ex_id (
        .rs1(id_rs1), .rs2(id_rs2), .use1(id_use1), .use2(id_use2),
        .wa(ex_wa), .we(ex_RegWrite), .hit1(ex_hit1), .hit2(ex_hit2)
    );

`ifdef HAZARD_FORWARD_EN
    logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;

    hazard_match #(.AW(AW)) u_mem_ex (
        .rs1(ex_rs1), .rs2(ex_rs2), .use1(1'b1), .use2(1'b1),
        .wa(mem_wa), .we(mem_RegWrite), .hit1(mem_hit1), .hit2(mem_hit2)
    );
    hazard_match #(.AW(AW)) u_wb_ex (
        .rs1(ex_rs1), .rs2(ex_rs2), .use1(1'b1), .use2(1'b1),
        .wa(wb_wa), .we(wb_RegWrite), .hit1(wb_hit1), .hit2(wb_hit2)
    );

    // Only a load in EX cannot be bypassed in time
    assign stall = ex_MemRead && (ex_hit1 || ex_hit2);
    // Youngest producer (MEM) wins over WB
    assign fwd_a = !rst_n ? FWD_RF : mem_hit1 ? FWD_EXMEM : wb_hit1 ? FWD_MEMWB : FWD_RF;
    assign fwd_b = !rst_n ? FWD_RF : mem_hit2 ? FWD_EXMEM : wb_hit2 ? FWD_MEMWB : FWD_RF;
`else
    logic mem_hit1, mem_hit2;
    logic unused_ok;

    hazard_match #(.AW(AW)) u_mem_id (
        .rs1(id_rs1), .rs2(id_rs2), .use1(id_use1), .use2(id_use2),
        .wa(mem_wa), .we(mem_RegWrite), .hit1(mem_hit1), .hit2(mem_hit2)
    );

    // WB is written before the regfile read, so only EX/MEM producers stall
    assign stall     = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
    assign fwd_a     = FWD_RF;
    assign fwd_b     = FWD_RF;
    assign unused_ok = ^{ex_rs1, ex_rs2, wb_wa, wb_RegWrite, ex_MemRead};
`endif

    assign is_init = (state == INIT);
    // mem_req is only honoured from RUN; MEM_WAIT holds until mem_ready regardless
    assign freeze  = ((state == RUN) && mem_req && !mem_ready) || ((state == MEM_WAIT) && !mem_ready);
    assign go      = rst_n && !is_init && !freeze;

    // A taken branch overrides any data stall: the stalled instruction is squashed anyway
    assign pc_en      = go && (ex_branch_taken || !stall);
    assign ifid_en    = pc_en;
    assign idex_en    = rst_n && !freeze;
    assign exmem_en   = idex_en;
    assign memwb_en   = idex_en;
    assign ifid_flush = is_init || (go && ex_branch_taken);
    assign idex_flush = is_init || (go && (ex_branch_taken || stall));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= INIT_LOAD;
            stall_cnt <= '0;
        end else begin
            state <= is_init ? ((init_cnt == '0) ? RUN : INIT) : (freeze ? MEM_WAIT : RUN);
            if (is_init && (init_cnt != '0))
                init_cnt <= init_cnt - IW'(1);
            if (!is_init && !pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of reset, init bubbles, stalls, freeze, branch and bypass
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0;
    logic [7:0] ex_wa = '0, mem_wa = '0, wb_wa = '0;
    logic       id_use1 = 0, id_use2 = 0, ex_RegWrite = 0, ex_MemRead = 0;
    logic       mem_RegWrite = 0, wb_RegWrite = 0, ex_branch_taken = 0;
    logic       mem_req = 0, mem_ready = 0;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cnt;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.AW(8), .INIT_FLUSH(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_wa(ex_wa), .ex_RegWrite(ex_RegWrite),
        .ex_MemRead(ex_MemRead), .mem_wa(mem_wa), .mem_RegWrite(mem_RegWrite),
        .wb_wa(wb_wa), .wb_RegWrite(wb_RegWrite), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 8'h00);
        chk("rst_flush", {ifid_flush, idex_flush}, 8'h03);
        chk("rst_fwd", {fwd_a, fwd_b}, 8'h00);
        chk("rst_cnt", stall_cnt, 8'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("init1_en", {pc_en, ifid_en, exmem_en, memwb_en}, 8'h03);
        chk("init1_flush", {ifid_flush, idex_flush}, 8'h03);
        tick();
        chk("init2_en", {pc_en, ifid_en, exmem_en, memwb_en}, 8'h03);
        chk("init2_flush", {ifid_flush, idex_flush}, 8'h03);
        tick();
        chk("run_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 8'h1f);
        chk("run_flush", {ifid_flush, idex_flush}, 8'h00);
        chk("run_cnt", stall_cnt, 8'h0);

        // load-use on r3
        ex_MemRead = 1; ex_RegWrite = 1; ex_wa = 8'h03; id_rs1 = 8'h03; id_use1 = 1;
        #1;
        chk("lu_en", {pc_en, ifid_en, exmem_en, memwb_en}, 8'h03);
        chk("lu_flush", {ifid_flush, idex_flush}, 8'h01);
        tick();
        ex_MemRead = 0; ex_RegWrite = 0;
        #1;
        chk("lu_cnt", stall_cnt, 8'h1);
        chk("lu_release", pc_en, 1'b1);

        // register 0 is ordinary; unused source does not stall
        ex_MemRead = 1; ex_RegWrite = 1; ex_wa = 8'h00; id_rs1 = 8'h00; id_use1 = 0;
        #1;
        chk("r0_unused", pc_en, 1'b1);
        id_use1 = 1;
        #1;
        chk("r0_stall", pc_en, 1'b0);
        tick();
        ex_MemRead = 0; ex_RegWrite = 0; id_use1 = 0;
        #1;
        chk("r0_cnt", stall_cnt, 8'h2);

        // bypass selection for rs2
        ex_rs2 = 8'h05; mem_wa = 8'h05; wb_wa = 8'h05; mem_RegWrite = 1; wb_RegWrite = 1;
        #1;
`ifdef HAZARD_FORWARD_EN
        chk("fwd_mem", {fwd_a, fwd_b}, 8'h01);
`else
        chk("fwd_off", {fwd_a, fwd_b}, 8'h00);
`endif
        chk("fwd_nostall", pc_en, 1'b1);
        mem_RegWrite = 0;
        #1;
`ifdef HAZARD_FORWARD_EN
        chk("fwd_wb", {fwd_a, fwd_b}, 8'h02);
`else
        chk("fwd_off_wb", {fwd_a, fwd_b}, 8'h00);
`endif
        wb_RegWrite = 0;
        #1;
        chk("fwd_rf", {fwd_a, fwd_b}, 8'h00);
        mem_wa = 8'h00; wb_wa = 8'h00; ex_rs2 = 8'h00;

        // memory wait 4 cycles, branch pending is held until exit
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wait_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 8'h00);
            chk("wait_flush", {ifid_flush, idex_flush}, 8'h00);
            tick();
        end
        mem_ready = 1;
        #1;
        chk("resume_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 8'h1f);
        chk("resume_flush", {ifid_flush, idex_flush}, 8'h03);
        chk("wait_cnt", stall_cnt, 8'h6);
        tick();
        mem_req = 0; mem_ready = 0; ex_branch_taken = 0;
        #1;
        chk("post_wait_cnt", stall_cnt, 8'h6);
        chk("post_wait_flush", {ifid_flush, idex_flush}, 8'h00);

        // branch cancels a concurrent load-use
        ex_branch_taken = 1; ex_MemRead = 1; ex_RegWrite = 1; ex_wa = 8'h02; id_rs1 = 8'h02; id_use1 = 1;
        #1;
        chk("br_en", {pc_en, ifid_en}, 8'h03);
        chk("br_flush", {ifid_flush, idex_flush}, 8'h03);
        tick();
        ex_branch_taken = 0; ex_MemRead = 0; ex_RegWrite = 0; id_use1 = 0;
        #1;
        chk("br_cnt", stall_cnt, 8'h6);

        // ALU producer of r7 walking EX -> MEM -> WB
        ex_RegWrite = 1; ex_wa = 8'h07; id_rs2 = 8'h07; id_use2 = 1;
        #1;
`ifdef HAZARD_FORWARD_EN
        chk("raw_ex", pc_en, 1'b1);
`else
        chk("raw_ex", pc_en, 1'b0);
`endif
        tick();
        ex_RegWrite = 0; mem_wa = 8'h07; mem_RegWrite = 1;
        #1;
`ifdef HAZARD_FORWARD_EN
        chk("raw_mem", pc_en, 1'b1);
`else
        chk("raw_mem", pc_en, 1'b0);
`endif
        tick();
        mem_RegWrite = 0; wb_wa = 8'h07; wb_RegWrite = 1;
        #1;
        chk("raw_wb", pc_en, 1'b1);
        tick();
        wb_RegWrite = 0; id_use2 = 0;
        #1;
`ifdef HAZARD_FORWARD_EN
        chk("raw_cnt", stall_cnt, 8'h6);
`else
        chk("raw_cnt", stall_cnt, 8'h8);
`endif

        // counter saturates at all-ones
        mem_req = 1; mem_ready = 0;
        repeat (10) tick();
        chk("sat_cnt", stall_cnt, 8'hf);
        tick();
        chk("sat_hold", stall_cnt, 8'hf);
        chk("sat_frozen", pc_en, 1'b0);

        // reset in the middle of a wait
        #1 rst_n = 0;
        #1;
        chk("mid_rst_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 8'h00);
        chk("mid_rst_flush", {ifid_flush, idex_flush}, 8'h03);
        chk("mid_rst_cnt", stall_cnt, 8'h0);
        tick();
        rst_n = 1;
        #1;
        chk("reinit1", {pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush}, 8'h0f);
        tick();
        chk("reinit2", {pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush}, 8'h0f);
        tick();
        chk("rerun_freeze", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 8'h00);
        mem_req = 0;
        #1;
        chk("rerun_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 8'h1f);
        chk("rerun_cnt", stall_cnt, 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
